// File: rtl/parking_pkg.sv
// Shared display state codes for the parking barrier controller and display decoder.
package parking_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_ENTRY     = 3'd1,
      ST_EXIT      = 3'd2,
      ST_EXIT_DONE = 3'd3,
      ST_FULL      = 3'd4
   } state_e;

endpackage

// File: rtl/btn_edge.sv
// Button history register with a rising-edge request pulse.
module btn_edge (
   input  logic ms,
   input  logic rst,
   input  logic btn_i,
   output logic rise_c
);

   logic hist_q;

   always_ff @(posedge ms) begin
      if (rst) hist_q <= 1'b0;
      else     hist_q <= btn_i;
   end

   assign rise_c = btn_i & ~hist_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-barrier car park controller: arbitrates entry/exit requests, times the
// barrier, keeps a saturating occupancy count and drives the display state code.
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY = 8,
   parameter int unsigned COUNT_W  = 4,
   parameter int unsigned HOLD_MS  = 2000,
   parameter int unsigned DONE_MS  = 1000,
   parameter int unsigned TIMER_W  = 11
) (
   input  logic               ms,
   input  logic               rst,
   input  logic               press_in,
   input  logic               press_out,
   input  logic               car_passed,
   output logic               gate_open,
   output logic [STATE_W-1:0] state,
   output logic [COUNT_W-1:0] count,
   output logic               full
);

   localparam logic [COUNT_W-1:0] CAP_C  = COUNT_W'(CAPACITY);
   localparam logic [TIMER_W-1:0] HOLD_C = TIMER_W'(HOLD_MS - 1);
   localparam logic [TIMER_W-1:0] DONE_C = TIMER_W'(DONE_MS - 1);

   state_e             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               gate_q, gate_d;
   logic               full_q, full_d;
   logic               pend_in_q, pend_in_d;
   logic               pend_out_q, pend_out_d;
   logic               rise_in_c, rise_out_c;
   logic               req_in_c, req_out_c;

   btn_edge u_edge_in  (.ms(ms), .rst(rst), .btn_i(press_in),  .rise_c(rise_in_c));
   btn_edge u_edge_out (.ms(ms), .rst(rst), .btn_i(press_out), .rise_c(rise_out_c));

   // A same-cycle edge counts as a request so IDLE reacts with no added latency.
   assign req_in_c  = pend_in_q  | rise_in_c;
   assign req_out_c = pend_out_q | rise_out_c;

   always_ff @(posedge ms) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         count_q    <= '0;
         gate_q     <= 1'b0;
         full_q     <= 1'b0;
         pend_in_q  <= 1'b0;
         pend_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         count_q    <= count_d;
         gate_q     <= gate_d;
         full_q     <= full_d;
         pend_in_q  <= pend_in_d;
         pend_out_q <= pend_out_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      count_d    = count_q;
      gate_d     = gate_q;
      pend_in_d  = req_in_c;
      pend_out_d = req_out_c;

      unique case (state_q)
         ST_IDLE: begin
            // Exit wins a tie; the entry flag stays set for a later visit to IDLE.
            if (req_out_c) begin
               pend_out_d = 1'b0;
               if (count_q != '0) begin
                  state_d = ST_EXIT;
                  timer_d = HOLD_C;
                  gate_d  = 1'b1;
               end
            end else if (req_in_c) begin
               pend_in_d = 1'b0;
               if (count_q < CAP_C) begin
                  state_d = ST_ENTRY;
                  timer_d = HOLD_C;
                  gate_d  = 1'b1;
               end else begin
                  state_d = ST_FULL;
                  timer_d = DONE_C;
               end
            end
         end
         ST_ENTRY: begin
            if (car_passed) begin
               if (count_q < CAP_C) count_d = count_q + COUNT_W'(1);
               gate_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (timer_q == '0) begin
               gate_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_EXIT: begin
            if (car_passed) begin
               if (count_q != '0) count_d = count_q - COUNT_W'(1);
               gate_d  = 1'b0;
               state_d = ST_EXIT_DONE;
               timer_d = DONE_C;
            end else if (timer_q == '0) begin
               gate_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_EXIT_DONE, ST_FULL: begin
            if (timer_q == '0) state_d = ST_IDLE;
            else               timer_d = timer_q - TIMER_W'(1);
         end
         default: begin
            state_d = ST_IDLE;
            gate_d  = 1'b0;
         end
      endcase

      full_d = (count_d == CAP_C);
   end

   assign gate_open = gate_q;
   assign state     = state_q;
   assign count     = count_q;
   assign full      = full_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with HOLD_MS=5, DONE_MS=3, CAPACITY=2.
module tb_parking_gate_ctrl;

   logic       ms;
   logic       rst;
   logic       press_in;
   logic       press_out;
   logic       car_passed;
   logic       gate_open;
   logic [2:0] state;
   logic [3:0] count;
   logic       full;

   int n_pass;
   int n_total;

   parking_gate_ctrl #(
      .CAPACITY(2), .COUNT_W(4), .HOLD_MS(5), .DONE_MS(3), .TIMER_W(11)
   ) dut (
      .ms(ms), .rst(rst), .press_in(press_in), .press_out(press_out),
      .car_passed(car_passed), .gate_open(gate_open), .state(state),
      .count(count), .full(full)
   );

   initial ms = 1'b0;
   always #5 ms = ~ms;

   task automatic tick();
      @(posedge ms);
      #1;
   endtask

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   initial begin
      int gate_hi;
      int entries;
      int full_cyc;
      int gate_seen;
      logic [2:0] prev_state;

      n_pass = 0; n_total = 0;
      rst = 1'b1; press_in = 1'b0; press_out = 1'b0; car_passed = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_eq("rst_state", int'(state), 0);
      chk_eq("rst_gate", int'(gate_open), 0);
      chk_eq("rst_count", int'(count), 0);
      chk_eq("rst_full", int'(full), 0);

      // Entry with a car passing two cycles after the press
      press_in = 1'b1; tick();
      chk_eq("t1_state_entry", int'(state), 1);
      chk_eq("t1_gate_open", int'(gate_open), 1);
      press_in = 1'b0; tick();
      car_passed = 1'b1; tick(); car_passed = 1'b0;
      chk_eq("t1_state_idle", int'(state), 0);
      chk_eq("t1_count", int'(count), 1);
      chk_eq("t1_gate_closed", int'(gate_open), 0);
      chk_eq("t1_full", int'(full), 0);

      // Held button, no car: one entry, gate open five cycles
      gate_hi = 0; entries = 0; prev_state = state;
      press_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gate_open) gate_hi++;
         if (state == 3'd1 && prev_state != 3'd1) entries++;
         prev_state = state;
      end
      press_in = 1'b0; tick();
      chk_eq("t2_gate_cycles", gate_hi, 5);
      chk_eq("t2_entries", entries, 1);
      chk_eq("t2_state", int'(state), 0);
      chk_eq("t2_count", int'(count), 1);

      // Fill the park
      press_in = 1'b1; tick(); press_in = 1'b0;
      car_passed = 1'b1; tick(); car_passed = 1'b0;
      chk_eq("fill_count", int'(count), 2);
      chk_eq("fill_full", int'(full), 1);

      // Entry refused while full; spurious car_passed ignored
      full_cyc = 0; gate_seen = 0;
      press_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) begin
            press_in = 1'b0;
            chk_eq("t3_state_full", int'(state), 4);
         end
         car_passed = (i == 1);
         if (state == 3'd4) full_cyc++;
         if (gate_open) gate_seen++;
      end
      car_passed = 1'b0;
      chk_eq("t3_full_cycles", full_cyc, 3);
      chk_eq("t3_gate_never", gate_seen, 0);
      chk_eq("t3_state_end", int'(state), 0);
      chk_eq("t3_count", int'(count), 2);
      chk_eq("t3_full", int'(full), 1);

      // One exit to bring count to 1
      press_out = 1'b1; tick(); press_out = 1'b0;
      chk_eq("ex_state", int'(state), 2);
      chk_eq("ex_gate", int'(gate_open), 1);
      car_passed = 1'b1; tick(); car_passed = 1'b0;
      chk_eq("ex_done_state", int'(state), 3);
      chk_eq("ex_count", int'(count), 1);
      chk_eq("ex_full", int'(full), 0);
      tick(); tick(); tick();
      chk_eq("ex_back_idle", int'(state), 0);

      // Simultaneous requests: exit first, pending entry after one IDLE cycle
      press_in = 1'b1; press_out = 1'b1; tick();
      press_in = 1'b0; press_out = 1'b0;
      chk_eq("t4_exit_first", int'(state), 2);
      car_passed = 1'b1; tick(); car_passed = 1'b0;
      chk_eq("t4_done", int'(state), 3);
      chk_eq("t4_count", int'(count), 0);
      tick(); chk_eq("t4_done2", int'(state), 3);
      tick(); chk_eq("t4_done3", int'(state), 3);
      tick(); chk_eq("t4_idle", int'(state), 0);
      tick(); chk_eq("t4_entry_served", int'(state), 1);
      chk_eq("t4_entry_gate", int'(gate_open), 1);
      for (int i = 0; i < 5; i++) tick();
      chk_eq("t4_timeout_state", int'(state), 0);
      chk_eq("t4_timeout_count", int'(count), 0);

      // Spurious car_passed in IDLE at zero count does not underflow
      car_passed = 1'b1; tick(); car_passed = 1'b0;
      chk_eq("underflow_count", int'(count), 0);

      // Exit with empty park is dropped and leaves no pending flag
      press_out = 1'b1; tick(); press_out = 1'b0;
      chk_eq("t5_state", int'(state), 0);
      chk_eq("t5_gate", int'(gate_open), 0);
      tick();
      press_in = 1'b1; tick(); press_in = 1'b0;
      chk_eq("t5_entry_direct", int'(state), 1);
      car_passed = 1'b1; tick(); car_passed = 1'b0;
      chk_eq("t5_count", int'(count), 1);

      // Reset during EXIT_OPEN with count=2 and a queued entry
      press_in = 1'b1; tick(); press_in = 1'b0;
      car_passed = 1'b1; tick(); car_passed = 1'b0;
      chk_eq("t6_count2", int'(count), 2);
      press_out = 1'b1; tick(); press_out = 1'b0;
      chk_eq("t6_exit", int'(state), 2);
      press_in = 1'b1; tick(); press_in = 1'b0;
      chk_eq("t6_no_preempt", int'(state), 2);
      rst = 1'b1; tick(); rst = 1'b0;
      chk_eq("t6_rst_state", int'(state), 0);
      chk_eq("t6_rst_gate", int'(gate_open), 0);
      chk_eq("t6_rst_count", int'(count), 0);
      chk_eq("t6_rst_full", int'(full), 0);
      tick(); tick();
      chk_eq("t6_queue_dropped", int'(state), 0);
      chk_eq("t6_gate_still", int'(gate_open), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Single-barrier controller for the car park.
- Arbitrates between the entry and exit push-buttons, which share one barrier and one status display.
- Times how long the barrier stays open, keeps the occupancy count, and drives the 3-bit display state code.
- Sits between the debounced button/sensor inputs and the display/barrier drivers; all timing is in ticks of the 1 kHz ms clock.

Parameters:
- CAPACITY, 8, number of bays; entry is refused when count equals CAPACITY.
- COUNT_W, 4, width of count; must hold CAPACITY.
- HOLD_MS, 2000, ms the barrier stays open waiting for a car to pass.
- DONE_MS, 1000, ms the "exit complete" and "full" messages are shown.
- TIMER_W, 11, timer width; must hold max(HOLD_MS, DONE_MS).

Ports:
- ms  input  1  1 kHz clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- press_in  input  1  entry button, level, debounced.
- press_out  input  1  exit button, level, debounced.
- car_passed  input  1  barrier loop sensor, one-cycle pulse when a car clears the barrier.
- gate_open  output  1  barrier raise command.
- state  output  3  display code: 0 idle, 1 entering, 2 exiting, 3 exit complete, 4 full.
- count  output  COUNT_W  cars currently parked.
- full  output  1  count == CAPACITY.

Behaviour:
- Clock and reset: one clock, ms, posedge only. Reset is synchronous and active-high on rst.
- Reset values: state=0, gate_open=0, count=0, full=0, timer=0, both pending flags=0, button history regs=0.
- Reset mid-operation: any FSM state returns to IDLE on the next edge. The barrier drops and the count is lost; this is intentional, and a power-on recount is done by the operator.
- Button edges: each button has a history reg. A request is a rising edge (current=1, previous=0). Holding a button produces exactly one request.
- Pending requests: each request sets its pending flag. A flag clears only when its request is served or rejected.
- Outputs: all registered. gate_open and state change on the same edge as the FSM transition.
- FSM states and display codes: IDLE(0), ENTRY_OPEN(1), EXIT_OPEN(2), EXIT_DONE(3), FULL_SHOW(4).
- IDLE, request selection: the effective request is pending OR this-cycle edge, so there is zero-cycle latency from edge to transition. If both are active, exit has priority. The entry pending flag stays set and is served on a later return to IDLE.
- IDLE, exit selected, count>0: go to EXIT_OPEN, load timer=HOLD_MS-1, gate_open=1, clear exit pending.
- IDLE, exit selected, count==0: exit pending cleared, stay IDLE, nothing else happens.
- IDLE, entry selected, count<CAPACITY: go to ENTRY_OPEN, load timer=HOLD_MS-1, gate_open=1, clear entry pending.
- IDLE, entry selected, count==CAPACITY: go to FULL_SHOW, load timer=DONE_MS-1, clear entry pending, gate stays closed.
- ENTRY_OPEN: car_passed → count+1, gate_open=0, go to IDLE. If timer==0 without car_passed → gate_open=0, go to IDLE, count unchanged. Otherwise timer decrements.
- EXIT_OPEN: car_passed → count-1, gate_open=0, go to EXIT_DONE with timer=DONE_MS-1. If timer==0 without car_passed → go to IDLE, count unchanged.
- car_passed coinciding with timer==0: car_passed wins.
- EXIT_DONE and FULL_SHOW: timer decrements; at timer==0 → IDLE.
- Requests in non-IDLE states: button edges only set pending flags and never preempt. The FSM spends at least one cycle in IDLE between services, so a pending request is served on the cycle after the FSM enters IDLE.
- Count arithmetic: saturating. Never exceeds CAPACITY and never underflows below 0, even on spurious car_passed. car_passed in IDLE/EXIT_DONE/FULL_SHOW is ignored.
- full: registered and equal to (next count == CAPACITY).

Decomposition:
- Package parking_pkg: state code constants ST_IDLE..ST_FULL (3-bit), shared with the display decoder.
- Sub-module btn_edge: history reg plus rising-edge pulse, instantiated twice.
- FSM, timer and counter stay in the top block.

Test Plan (HOLD_MS=5, DONE_MS=3, CAPACITY=2):
- Reset, then press_in pulse, car_passed 2 cycles later → state 1 and gate_open=1 from the press edge; state 0, count=1 after the pass.
- press_in held 20 cycles with no car_passed → exactly one entry; gate_open high for 5 cycles, then state 0, count unchanged.
- count=2, press_in → state 4 for 3 cycles, gate_open stays 0, full=1, count=2.
- press_in and press_out rise on the same cycle with count=1 → EXIT_OPEN first. After car_passed, count=0 and state 3 for 3 cycles, then 1 cycle in IDLE, then ENTRY_OPEN (pending entry served).
- press_out with count=0 → state stays 0, gate_open stays 0, exit pending cleared.
- rst asserted during EXIT_OPEN with count=2 → next edge: state=0, gate_open=0, count=0, full=0; a press queued before the reset is not served.
